// File: rtl/sweep_sequencer.sv
// Host-driven S-parameter sweep scheduler in front of the RF switcher.
// Optional acquisition timeout enabled by defining SEQ_TIMEOUT_EN.
module sweep_sequencer #(
  parameter int SETTLE_CYCLES  = 50,
  parameter int TRIG_CYCLES    = 25,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 16
) (
  input  logic             Clk,
  input  logic             nRst,
  input  logic             start,
  input  logic             abort,
  input  logic [2:0]       port_mask,
  input  logic [CNT_W-1:0] num_sweeps,
  input  logic             VNA_RDY,
  output logic [1:0]       new_state,
  output logic             new_state_arrived,
  output logic             VNA_TRIG,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic [1:0]       cur_port,
  output logic [CNT_W-1:0] sweep_cnt
);

  localparam int PH_MAX =
    (SETTLE_CYCLES > TRIG_CYCLES) ? SETTLE_CYCLES : TRIG_CYCLES;
  localparam int PW = $clog2(PH_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, SELECT, SETTLE, TRIG, WAIT_ACQ, NEXT, FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ph_q, ph_d;
  logic [2:0]       mask_q, mask_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]       cur_q, cur_d;
  logic [1:0]       ns_q, ns_d;
  logic [1:0]       nxt;
  logic             terr_q, terr_d;
  logic             rdy1_q, rdy2_q, rdy3_q;
  logic             acq_done;
  logic             stb_q, trig_q, busy_q, done_q;

`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_q, to_d;
`endif

  // next set bit strictly above c, wrapping 2->0 (returns c if it is the only one)
  function automatic logic [1:0] next_port(input logic [2:0] m,
                                           input logic [1:0] c);
    logic [1:0] r;
    logic       f;
    int         idx;
    r = c;
    f = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      idx = (int'(c) + k) % 3;
      if (!f && m[idx]) begin
        r = 2'(idx);
        f = 1'b1;
      end
    end
    return r;
  endfunction

  assign acq_done = rdy2_q & ~rdy3_q;
  assign nxt      = next_port(mask_q, cur_q);
  assign cnt_inc  = (nxt <= cur_q) ? cnt_q + 1'b1 : cnt_q;

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    mask_d  = mask_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    ns_d    = ns_q;
    terr_d  = terr_q;
`ifdef SEQ_TIMEOUT_EN
    to_d    = to_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start && !abort && (port_mask != 3'b000)) begin
          mask_d  = port_mask;
          num_d   = num_sweeps;
          cnt_d   = '0;
          terr_d  = 1'b0;
          cur_d   = next_port(port_mask, 2'd2);
          ns_d    = next_port(port_mask, 2'd2);
          state_d = SELECT;
        end
      end
      SELECT: begin
        ph_d    = '0;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (ph_q >= PW'(SETTLE_CYCLES - 1)) begin
          ph_d    = '0;
          state_d = TRIG;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      TRIG: begin
        if (ph_q >= PW'(TRIG_CYCLES - 1)) begin
          ph_d    = '0;
          state_d = WAIT_ACQ;
`ifdef SEQ_TIMEOUT_EN
          to_d    = '0;
`endif
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      WAIT_ACQ: begin
        if (acq_done) begin
          state_d = NEXT;
`ifdef SEQ_TIMEOUT_EN
        end else if (to_q >= TW'(TIMEOUT_CYCLES - 1)) begin
          terr_d  = 1'b1;
          state_d = FINISH;
        end else begin
          to_d = to_q + 1'b1;
`endif
        end
      end
      NEXT: begin
        cnt_d = cnt_inc;
        if ((num_q != '0) && (cnt_inc == num_q)) begin
          state_d = FINISH;
        end else begin
          cur_d   = nxt;
          ns_d    = nxt;
          state_d = SELECT;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // abort overrides whatever the state decided this cycle
    if (abort && (state_q != IDLE) && (state_q != FINISH)) begin
      state_d = FINISH;
      cnt_d   = cnt_q;
      cur_d   = cur_q;
      ns_d    = ns_q;
      terr_d  = terr_q;
    end
  end

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
      ph_q    <= '0;
      mask_q  <= '0;
      num_q   <= '0;
      cnt_q   <= '0;
      cur_q   <= '0;
      ns_q    <= '0;
      terr_q  <= 1'b0;
      rdy1_q  <= 1'b0;
      rdy2_q  <= 1'b0;
      rdy3_q  <= 1'b0;
      stb_q   <= 1'b0;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      mask_q  <= mask_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      ns_q    <= ns_d;
      terr_q  <= terr_d;
      rdy1_q  <= VNA_RDY;
      rdy2_q  <= rdy1_q;
      rdy3_q  <= rdy2_q;
      stb_q   <= (state_d == SELECT);
      trig_q  <= (state_d == TRIG);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == FINISH);
    end
  end

`ifdef SEQ_TIMEOUT_EN
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end
`endif

  assign new_state         = ns_q;
  assign new_state_arrived = stb_q;
  assign VNA_TRIG          = trig_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign timeout_err       = terr_q;
  assign cur_port          = cur_q;
  assign sweep_cnt         = cnt_q;

endmodule

// File: tb/tb_sweep_sequencer.sv
// Scoreboard bench for sweep_sequencer: random sweeps vs a port-list model.
// Directed cases cover latency, abort, mask=0, continuous mode, timeout, reset.
module tb_sweep_sequencer;

  localparam int CNT_W = 16;

  logic             Clk = 1'b0;
  logic             nRst = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [2:0]       port_mask = '0;
  logic [CNT_W-1:0] num_sweeps = '0;
  logic             VNA_RDY = 1'b0;
  logic [1:0]       new_state;
  logic             new_state_arrived;
  logic             VNA_TRIG;
  logic             busy;
  logic             done;
  logic             timeout_err;
  logic [1:0]       cur_port;
  logic [CNT_W-1:0] sweep_cnt;

  sweep_sequencer #(
    .SETTLE_CYCLES(4), .TRIG_CYCLES(3),
    .TIMEOUT_CYCLES(100), .CNT_W(CNT_W)
  ) dut (
    .Clk(Clk), .nRst(nRst), .start(start), .abort(abort),
    .port_mask(port_mask), .num_sweeps(num_sweeps),
    .VNA_RDY(VNA_RDY), .new_state(new_state),
    .new_state_arrived(new_state_arrived), .VNA_TRIG(VNA_TRIG),
    .busy(busy), .done(done), .timeout_err(timeout_err),
    .cur_port(cur_port), .sweep_cnt(sweep_cnt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int cnt;
    bit terr;
  } done_t;

  int    checks = 0;
  int    errors = 0;
  int    exp_ports[$];
  done_t exp_done[$];
  int    done_seen = 0;
  bit    resp_en = 1'b0;
  int    resp_limit = 1000000;
  int    acq_cnt = 0;
  bit    trig_short_ok = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // reference: ports visited in ascending order, num passes, then done
  task automatic push_model(input logic [2:0] m, input int n, input bit te);
    done_t d;
    for (int p = 0; p < n; p++)
      for (int b = 0; b < 3; b++)
        if (m[b]) exp_ports.push_back(b);
    d.cnt  = n;
    d.terr = te;
    exp_done.push_back(d);
  endtask

  // monitor: strobes, done pulses, trigger width
  initial begin
    int w;
    int p;
    done_t d;
    w = 0;
    forever begin
      @(negedge Clk);
      if (new_state_arrived) begin
        if (exp_ports.size() == 0) begin
          chk("unexpected_strobe", new_state, -1);
        end else begin
          p = exp_ports.pop_front();
          chk("strobe_port", new_state, p);
        end
      end
      if (done) begin
        done_seen++;
        if (exp_done.size() == 0) begin
          chk("unexpected_done", sweep_cnt, -1);
        end else begin
          d = exp_done.pop_front();
          chk("done_cnt", sweep_cnt, d.cnt);
          chk("done_terr", timeout_err, d.terr);
          chk("done_trig_low", VNA_TRIG, 0);
          chk("done_busy", busy, 1);
        end
      end
      if (VNA_TRIG) begin
        w++;
      end else if (w > 0) begin
        if (!trig_short_ok) chk("trig_width", w, 3);
        w = 0;
      end
    end
  end

  // responder: acquisition completes a random delay after each trigger
  initial begin
    bit prev;
    int dl;
    prev = 1'b0;
    forever begin
      @(negedge Clk);
      if (resp_en && prev && !VNA_TRIG && acq_cnt < resp_limit) begin
        dl = $urandom_range(1, 8);
        repeat (dl) @(negedge Clk);
        VNA_RDY = 1'b1;
        repeat (2) @(negedge Clk);
        VNA_RDY = 1'b0;
        acq_cnt++;
      end
      prev = VNA_TRIG;
    end
  end

  task automatic do_start(input logic [2:0] m, input int n);
    @(negedge Clk);
    port_mask  = m;
    num_sweeps = CNT_W'(n);
    start      = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    chk("start_latency", new_state_arrived, 1);
  endtask

  task automatic wait_done(input string nm, input int budget);
    int base;
    int n;
    base = done_seen;
    n = 0;
    while (done_seen == base && n < budget) begin
      @(negedge Clk);
      n++;
    end
    chk(nm, done_seen - base, 1);
  endtask

  task automatic wait_trig(input bit lvl, input int budget);
    int n;
    n = 0;
    while (VNA_TRIG != lvl && n < budget) begin
      @(negedge Clk);
      n++;
    end
    chk("wait_trig", VNA_TRIG, lvl);
  endtask

  initial begin
    logic [2:0] m;
    int n;

    // reset state
    @(negedge Clk);
    chk("rst_busy", busy, 0);
    chk("rst_trig", VNA_TRIG, 0);
    chk("rst_cnt", sweep_cnt, 0);
    chk("rst_done", done, 0);
    nRst = 1'b1;
    repeat (2) @(negedge Clk);

    // first trigger rises on the 5th sample after the strobe sample
    push_model(3'b101, 2, 1'b0);
    resp_en = 1'b1;
    do_start(3'b101, 2);
    n = 0;
    while (!VNA_TRIG && n < 20) begin
      @(negedge Clk);
      n++;
    end
    chk("trig_rise_lat", n, 5);
    wait_done("done_101x2", 2000);
    @(negedge Clk);
    chk("idle_after_101", busy, 0);
    chk("cur_port_hold", cur_port, 2);

    // random sweeps
    for (int it = 0; it < 8; it++) begin
      m = 3'($urandom_range(1, 7));
      n = $urandom_range(1, 3);
      push_model(m, n, 1'b0);
      do_start(m, n);
      wait_done("done_rand", 3000);
      repeat (2) @(negedge Clk);
    end

    // continuous single port, abort after five passes
    acq_cnt    = 0;
    resp_limit = 5;
    for (int i = 0; i < 6; i++) exp_ports.push_back(1);
    begin
      done_t d;
      d.cnt  = 5;
      d.terr = 1'b0;
      exp_done.push_back(d);
    end
    do_start(3'b010, 0);
    n = 0;
    while (sweep_cnt != 5 && n < 2000) begin
      @(negedge Clk);
      n++;
    end
    chk("cont_cnt", sweep_cnt, 5);
    repeat (2) @(negedge Clk);
    abort = 1'b1;
    @(negedge Clk);
    abort = 1'b0;
    chk("cont_abort_done", done, 1);
    chk("cont_abort_trig", VNA_TRIG, 0);
    @(negedge Clk);
    chk("cont_idle", busy, 0);
    resp_limit = 1000000;
    resp_en    = 1'b0;

    // abort in the middle of the trigger pulse
    push_model(3'b001, 1, 1'b0);
    exp_done[exp_done.size()-1].cnt = 0;
    do_start(3'b001, 1);
    wait_trig(1'b1, 50);
    trig_short_ok = 1'b1;
    abort = 1'b1;
    @(negedge Clk);
    abort = 1'b0;
    chk("abort_trig_low", VNA_TRIG, 0);
    chk("abort_done", done, 1);
    @(negedge Clk);
    chk("abort_idle", busy, 0);
    trig_short_ok = 1'b0;

    // empty mask and start+abort are both ignored
    port_mask = 3'b000;
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    repeat (3) @(negedge Clk);
    chk("mask0_busy", busy, 0);
    port_mask = 3'b011;
    start = 1'b1;
    abort = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge Clk);
    chk("start_abort_busy", busy, 0);

    // VNA_RDY edge just before start must not advance the sequence
    VNA_RDY = 1'b1;
    push_model(3'b001, 1, 1'b0);
    do_start(3'b001, 1);
    wait_trig(1'b1, 50);
    wait_trig(1'b0, 50);
    repeat (5) @(negedge Clk);
    chk("early_rdy_busy", busy, 1);
    chk("early_rdy_cnt", sweep_cnt, 0);
    VNA_RDY = 1'b0;
    repeat (2) @(negedge Clk);
    VNA_RDY = 1'b1;
    repeat (2) @(negedge Clk);
    VNA_RDY = 1'b0;
    wait_done("done_early_rdy", 100);
    @(negedge Clk);

    // acquisition never completes
`ifdef SEQ_TIMEOUT_EN
    push_model(3'b100, 1, 1'b1);
    exp_done[exp_done.size()-1].cnt = 0;
    do_start(3'b100, 1);
    wait_trig(1'b1, 50);
    wait_trig(1'b0, 50);
    n = 1;
    while (!done && n < 300) begin
      @(negedge Clk);
      n++;
    end
    chk("timeout_latency", n, 101);
    chk("timeout_err_set", timeout_err, 1);
    @(negedge Clk);
    resp_en = 1'b1;
    push_model(3'b011, 1, 1'b0);
    do_start(3'b011, 1);
    chk("timeout_err_clr", timeout_err, 0);
    wait_done("done_after_to", 2000);
    resp_en = 1'b0;
`else
    push_model(3'b100, 1, 1'b0);
    exp_done[exp_done.size()-1].cnt = 0;
    do_start(3'b100, 1);
    repeat (1000) @(negedge Clk);
    chk("no_timeout_busy", busy, 1);
    chk("no_timeout_err", timeout_err, 0);
    abort = 1'b1;
    @(negedge Clk);
    abort = 1'b0;
    chk("no_timeout_done", done, 1);
`endif
    repeat (2) @(negedge Clk);

    // asynchronous reset while waiting for acquisition
    push_model(3'b110, 2, 1'b0);
    do_start(3'b110, 2);
    wait_trig(1'b1, 50);
    wait_trig(1'b0, 50);
    repeat (3) @(negedge Clk);
    chk("pre_rst_port", cur_port, 1);
    #2 nRst = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_new_state", new_state, 0);
    chk("arst_cur_port", cur_port, 0);
    chk("arst_trig", VNA_TRIG, 0);
    chk("arst_strobe", new_state_arrived, 0);
    exp_ports.delete();
    exp_done.delete();
    @(negedge Clk);
    nRst = 1'b1;
    repeat (3) @(negedge Clk);
    chk("post_rst_busy", busy, 0);

    chk("ports_left", exp_ports.size(), 0);
    chk("dones_left", exp_done.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
